// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with standard/FWFT read, occupancy count and sticky errors
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RESERVE    = 0,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  has_data,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int FULL_LEVEL = DEPTH - RESERVE;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] FULL_C  = FULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] mem_count;
  logic [ADDR_WIDTH:0] count_nxt;
  logic                out_valid;
  logic                out_valid_nxt;
  logic                wr_acc;
  logic                rd_acc;
  logic                mem_rd;

  // count includes the FWFT output register, so the storage array never exceeds DEPTH entries
  always_comb begin
    mem_count = wr_ptr - rd_ptr;
    wr_acc    = wr_en && (count < DEPTH_C);
    if (FWFT != 0) begin
      rd_acc        = rd_en && out_valid;
      mem_rd        = (mem_count != '0) && (!out_valid || rd_acc);
      out_valid_nxt = mem_rd || (out_valid && !rd_acc);
    end else begin
      rd_acc        = rd_en && (count != '0);
      mem_rd        = rd_acc;
      out_valid_nxt = 1'b0;
    end
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + ONE;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst && !flush) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      rd_data      <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      has_data     <= 1'b0;
      almost_empty <= 1'b1;
      if (rst) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (mem_rd) begin
        rd_ptr  <= rd_ptr + ONE;
        rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      count        <= count_nxt;
      full         <= (count_nxt >= FULL_C);
      almost_empty <= (count_nxt <= AE_C);
      out_valid    <= out_valid_nxt;
      if (FWFT != 0) begin
        empty    <= !out_valid_nxt;
        has_data <= out_valid_nxt;
      end else begin
        empty    <= (count_nxt == '0);
        has_data <= (count_nxt != '0);
      end
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - scoreboard bench driving a standard and an FWFT instance with shared stimulus
module tb_sync_fifo_flex;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic       s_full, s_empty, s_has_data, s_ae, s_ovf, s_unf;
  logic [7:0] s_rd_data;
  logic [2:0] s_count;
  logic       f_full, f_empty, f_has_data, f_ae, f_ovf, f_unf;
  logic [7:0] f_rd_data;
  logic [2:0] f_count;

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RESERVE(1), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(s_full),
    .rd_en(rd_en), .rd_data(s_rd_data), .empty(s_empty), .has_data(s_has_data),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RESERVE(0), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
    .rd_en(rd_en), .rd_data(f_rd_data), .empty(f_empty), .has_data(f_has_data),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: entry queues plus sticky flags; exp_* hold data owed to the monitor
  logic [7:0] sq[$];
  logic [7:0] fq[$];
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];
  bit         f_hv;
  bit         m_s_ovf, m_s_unf, m_f_ovf, m_f_unf;
  bit         s_pend;
  int         checks;
  int         errors;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit wacc;
    bit racc;
    if (rst || flush) begin
      sq.delete();
      fq.delete();
      exp_s.delete();
      exp_f.delete();
      f_hv = 1'b0;
      if (rst) begin
        m_s_ovf = 1'b0; m_s_unf = 1'b0;
        m_f_ovf = 1'b0; m_f_unf = 1'b0;
      end
    end else begin
      wacc = wr_en && (sq.size() < 4);
      racc = rd_en && (sq.size() > 0);
      if (wr_en && !wacc) m_s_ovf = 1'b1;
      if (rd_en && !racc) m_s_unf = 1'b1;
      if (racc) void'(sq.pop_front());
      if (wacc) begin
        sq.push_back(wr_data);
        exp_s.push_back(wr_data);
      end
      // FWFT: the head is visible after an edge iff an entry was already stored before it
      wacc = wr_en && (fq.size() < 4);
      racc = rd_en && f_hv;
      if (wr_en && !wacc) m_f_ovf = 1'b1;
      if (rd_en && !racc) m_f_unf = 1'b1;
      if (racc) void'(fq.pop_front());
      f_hv = (fq.size() > 0);
      if (wacc) begin
        fq.push_back(wr_data);
        exp_f.push_back(wr_data);
      end
    end
  endtask

  task automatic check_state();
    logic [8:0] act;
    logic [8:0] exp;
    act = {s_count, s_full, s_empty, s_has_data, s_ae, s_ovf, s_unf};
    exp = {3'(sq.size()), (sq.size() >= 3), (sq.size() == 0), (sq.size() != 0),
           (sq.size() <= 1), m_s_ovf, m_s_unf};
    check("std status {count,full,empty,has_data,ae,ovf,unf}", act, exp);
    act = {f_count, f_full, f_empty, f_has_data, f_ae, f_ovf, f_unf};
    exp = {3'(fq.size()), (fq.size() >= 4), !f_hv, f_hv, (fq.size() <= 2), m_f_ovf, m_f_unf};
    check("fwft status {count,full,empty,has_data,ae,ovf,unf}", act, exp);
    if (rst || flush) begin
      check("std rd_data cleared", {1'b0, s_rd_data}, 9'h000);
      check("fwft rd_data cleared", {1'b0, f_rd_data}, 9'h000);
    end
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                     input logic fl, input logic rs);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    rst     = rs;
    @(posedge clk);
    #1;
    model_step();
    check_state();
  endtask

  // monitor: std data is due the cycle after an accepted read, FWFT data while has_data && rd_en
  initial begin
    logic [7:0] e;
    s_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (s_pend) begin
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL std rd_data at %0t: got %h with no entry expected", $time, s_rd_data);
        end else begin
          e = exp_s.pop_front();
          check("std rd_data", {1'b0, s_rd_data}, {1'b0, e});
        end
      end
      s_pend = rd_en && !s_empty && !rst && !flush;
      if (f_has_data && rd_en && !rst && !flush) begin
        if (exp_f.size() == 0) begin
          checks++; errors++;
          $display("FAIL fwft rd_data at %0t: got %h with no entry expected", $time, f_rd_data);
        end else begin
          e = exp_f.pop_front();
          check("fwft rd_data", {1'b0, f_rd_data}, {1'b0, e});
        end
      end
    end
  end

  initial begin
    int wp;
    int rp;
    checks = 0;
    errors = 0;
    f_hv = 1'b0;
    m_s_ovf = 1'b0; m_s_unf = 1'b0; m_f_ovf = 1'b0; m_f_unf = 1'b0;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);

    // fill through the reserve slack and past capacity, then drain past empty
    for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0, 0);

    // repeated fill/drain rounds with values 0..39
    cyc(0, 8'h00, 0, 0, 1);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) cyc(1, 8'(r * 4 + i), 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 0);
    end

    // single word fall-through latency
    cyc(1, 8'hA5, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);

    // streaming with read held high
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 100; i++) cyc(1, 8'(i), 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0, 0);

    // simultaneous read and write at count 2, then at count 0
    cyc(1, 8'h40, 0, 0, 0);
    cyc(1, 8'h41, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc(1, 8'($urandom), 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0, 0);
    cyc(1, 8'h5A, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);

    // flush with a concurrent write, then reuse
    for (int i = 0; i < 2; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0);
    cyc(1, 8'h99, 0, 1, 0);
    cyc(1, 8'h07, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);

    // mid-stream reset must discard stale entries
    cyc(1, 8'hE0, 0, 0, 0);
    cyc(1, 8'hE1, 0, 0, 0);
    cyc(1, 8'hEE, 1, 0, 1);
    cyc(1, 8'h11, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);

    // randomized traffic with varying fill bias, occasional flush and reset
    for (int ph = 0; ph < 6; ph++) begin
      wp = 20 + 15 * ph;
      rp = 95 - 15 * ph;
      for (int i = 0; i < 500; i++) begin
        cyc(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp),
            ($urandom_range(0, 127) == 0), ($urandom_range(0, 511) == 0));
      end
    end

    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
